// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-side front end.
// Provides register index / data widths, the r0 constant and the
// load-queue entry layout used by the top level and the load queue.
package regfile_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // One queued load result; live = 0 means it drains without a write.
    typedef struct packed {
        logic                 live;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular queue of load results with a per-entry live bit.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enq/enq_entry - push an entry (caller guarantees count != DEPTH)
//   deq           - pop the head (caller guarantees count != 0)
//   kill_en/kill_reg - clear live on every entry (stored or being pushed)
//                      whose register matches kill_reg
//   head          - entry at the read pointer
//   count         - number of occupied entries
//   pending_mask  - registered OR of one-hot(reg) over live entries
module wb_load_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq,
    input  wb_entry_t               enq_entry,
    input  logic                    deq,
    input  logic                    kill_en,
    input  logic [REG_IDX_W-1:0]    kill_reg,
    output wb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic [NUM_REGS-1:0]     pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t          entries   [DEPTH];
    wb_entry_t          entries_n [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
    logic [PTR_W:0]     count_n;
    logic [NUM_REGS-1:0] mask_n;

    assign head = entries[rd_ptr];

    always_comb begin
        entries_n = entries;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        mask_n    = '0;

        // Slots outside the occupied region always have live = 0, so the
        // kill compare can run over every slot without masking by pointers.
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].reg_idx == kill_reg) begin
                    entries_n[i].live = 1'b0;
                end
            end
        end

        if (deq) begin
            entries_n[rd_ptr].live = 1'b0;
            rd_ptr_n = rd_ptr + 1'b1;
        end

        // A load accepted alongside a matching ALU write counts as older.
        if (enq) begin
            entries_n[wr_ptr] = enq_entry;
            if (kill_en && (enq_entry.reg_idx == kill_reg)) begin
                entries_n[wr_ptr].live = 1'b0;
            end
            wr_ptr_n = wr_ptr + 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (entries_n[i].live) begin
                mask_n[entries_n[i].reg_idx] = 1'b1;
            end
        end
    end

    assign count_n = count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].live <= 1'b0;
            end
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            pending_mask <= mask_n;
            entries      <= entries_n;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results (never stall, absolute priority) and queued load
// results (valid/ready) onto the register file's single write port.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data     - ALU writeback, always accepted
//   mem_valid/mem_ready/mem_reg/mem_data - load writeback handshake
//   RegWrite/Write_Reg/Write_Bus   - registered register-file write port
//   pending_mask                   - registers targeted by live queued loads
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_IDX_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_IDX_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  RegWrite,
    output logic [REG_IDX_W-1:0]  Write_Reg,
    output logic [DATA_W-1:0]     Write_Bus,
    output logic [NUM_REGS-1:0]   pending_mask
);

    logic                   mem_accept;
    logic                   alu_write;
    logic                   deq;
    wb_entry_t              enq_entry;
    wb_entry_t              head;
    logic [$clog2(DEPTH):0] count;

    // Ready comes from the registered count only: no pass-through when full.
    assign mem_ready  = (count != (($clog2(DEPTH)+1))'(DEPTH));
    assign mem_accept = mem_valid && mem_ready;
    assign alu_write  = alu_valid && (alu_reg != REG_ZERO);
    // Any ALU cycle, even to r0, owns the write port.
    assign deq        = !alu_valid && (count != '0);

    assign enq_entry.live    = (mem_reg != REG_ZERO);
    assign enq_entry.reg_idx = mem_reg;
    assign enq_entry.data    = mem_data;

    wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .enq          (mem_accept),
        .enq_entry    (enq_entry),
        .deq          (deq),
        .kill_en      (alu_write),
        .kill_reg     (alu_reg),
        .head         (head),
        .count        (count),
        .pending_mask (pending_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            Write_Reg <= '0;
            Write_Bus <= '0;
        end else if (alu_valid) begin
            RegWrite <= alu_write;
            if (alu_write) begin
                Write_Reg <= alu_reg;
                Write_Bus <= alu_data;
            end
        end else if (deq) begin
            RegWrite <= head.live;
            if (head.live) begin
                Write_Reg <= head.reg_idx;
                Write_Bus <= head.data;
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        RegWrite;
    logic [4:0]  Write_Reg;
    logic [31:0] Write_Bus;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .RegWrite     (RegWrite),
        .Write_Reg    (Write_Reg),
        .Write_Bus    (Write_Bus),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (RegWrite !== 1'b0 || Write_Reg !== 5'd0 || Write_Bus !== 32'd0) begin
            errors++;
            $display("FAIL reset_port: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 0/0/0", RegWrite, Write_Reg, Write_Bus);
        end
        checks++;
        if (pending_mask !== 32'd0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mask_ready: mask=%h ready=%b want 0/1", pending_mask, mem_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: RegWrite=%b want 0", RegWrite);
        end
    endtask

    task automatic test_reset_mid_queue();
        // Keep ALU busy so two loads sit in the queue.
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_reg = 5'd20; mem_data = 32'h20;
        step();
        mem_reg = 5'd21; mem_data = 32'h21;
        step();
        checks++;
        if (pending_mask !== 32'h0030_0000 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL midq_fill: mask=%h ready=%b want 00300000/0", pending_mask, mem_ready);
        end
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if (RegWrite !== 1'b0 || Write_Reg !== 5'd0 || Write_Bus !== 32'd0 ||
            pending_mask !== 32'd0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL midq_reset: RegWrite=%b Write_Reg=%0d Write_Bus=%h mask=%h ready=%b want 0/0/0/0/1",
                     RegWrite, Write_Reg, Write_Bus, pending_mask, mem_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (RegWrite !== 1'b0) begin
                errors++;
                $display("FAIL midq_no_write[%0d]: RegWrite=%b want 0", k, RegWrite);
            end
        end
    endtask

    task automatic test_alu_single();
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        checks++;
        if (RegWrite !== 1'b1 || Write_Reg !== 5'd5 || Write_Bus !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_single: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 1/5/deadbeef", RegWrite, Write_Reg, Write_Bus);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || Write_Reg !== 5'd5 || Write_Bus !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_idle_hold: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 0/5/deadbeef", RegWrite, Write_Reg, Write_Bus);
        end
    endtask

    task automatic test_load_single();
        idle_inputs();
        mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'h1234;
        step();
        idle_inputs();
        checks++;
        if (pending_mask !== 32'h100 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL load_pending: mask=%h RegWrite=%b want 100/0", pending_mask, RegWrite);
        end
        step();
        checks++;
        if (RegWrite !== 1'b1 || Write_Reg !== 5'd8 || Write_Bus !== 32'h1234 || pending_mask !== 32'd0) begin
            errors++;
            $display("FAIL load_write: RegWrite=%b Write_Reg=%0d Write_Bus=%h mask=%h want 1/8/1234/0",
                     RegWrite, Write_Reg, Write_Bus, pending_mask);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL load_after: RegWrite=%b want 0", RegWrite);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1;
            alu_reg   = 5'(k + 1);
            alu_data  = 32'h100 + 32'(k);
            mem_valid = (k < 2);
            mem_reg   = (k == 0) ? 5'd9 : 5'd10;
            mem_data  = (k == 0) ? 32'h99 : 32'h1010;
            step();
            checks++;
            if (RegWrite !== 1'b1 || Write_Reg !== 5'(k + 1) || Write_Bus !== 32'h100 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_alu[%0d]: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 1/%0d/%h",
                         k, RegWrite, Write_Reg, Write_Bus, k + 1, 32'h100 + 32'(k));
            end
            if (k == 1) begin
                checks++;
                if (mem_ready !== 1'b0 || pending_mask !== 32'h0000_0600) begin
                    errors++;
                    $display("FAIL b2b_full: ready=%b mask=%h want 0/00000600", mem_ready, pending_mask);
                end
            end
        end
        idle_inputs();
        step();
        checks++;
        if (RegWrite !== 1'b1 || Write_Reg !== 5'd9 || Write_Bus !== 32'h99) begin
            errors++;
            $display("FAIL b2b_load9: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 1/9/99", RegWrite, Write_Reg, Write_Bus);
        end
        step();
        checks++;
        if (RegWrite !== 1'b1 || Write_Reg !== 5'd10 || Write_Bus !== 32'h1010 || pending_mask !== 32'd0) begin
            errors++;
            $display("FAIL b2b_load10: RegWrite=%b Write_Reg=%0d Write_Bus=%h mask=%h want 1/10/1010/0",
                     RegWrite, Write_Reg, Write_Bus, pending_mask);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drained: RegWrite=%b ready=%b want 0/1", RegWrite, mem_ready);
        end
    endtask

    task automatic test_kill();
        int r7_writes = 0;
        logic [31:0] r7_val = 32'h0;
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'hAAAA;
        step();
        checks++;
        if (pending_mask !== 32'h80) begin
            errors++;
            $display("FAIL kill_pending: mask=%h want 80", pending_mask);
        end
        mem_valid = 1'b0;
        alu_reg = 5'd7; alu_data = 32'h5555;
        step();
        idle_inputs();
        checks++;
        if (pending_mask !== 32'd0) begin
            errors++;
            $display("FAIL kill_mask: mask=%h want 0", pending_mask);
        end
        for (int k = 0; k < 4; k++) begin
            if (RegWrite === 1'b1 && Write_Reg === 5'd7) begin
                r7_writes++;
                r7_val = Write_Bus;
            end
            step();
        end
        checks++;
        if (r7_writes != 1 || r7_val !== 32'h5555) begin
            errors++;
            $display("FAIL kill_r7_writes: count=%0d last=%h want 1/5555", r7_writes, r7_val);
        end
        checks++;
        if (mem_ready !== 1'b1 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL kill_drain: ready=%b RegWrite=%b want 1/0", mem_ready, RegWrite);
        end
    endtask

    task automatic test_same_cycle_kill();
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'hB0B0;
        mem_valid = 1'b1; mem_reg = 5'd11; mem_data = 32'hC0C0;
        step();
        idle_inputs();
        checks++;
        if (pending_mask !== 32'd0 || RegWrite !== 1'b1 || Write_Bus !== 32'hB0B0) begin
            errors++;
            $display("FAIL same_kill: mask=%h RegWrite=%b Write_Bus=%h want 0/1/b0b0", pending_mask, RegWrite, Write_Bus);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || Write_Bus !== 32'hB0B0) begin
            errors++;
            $display("FAIL same_kill_drain: RegWrite=%b Write_Bus=%h want 0/b0b0", RegWrite, Write_Bus);
        end
    endtask

    task automatic test_r0();
        int writes = 0;
        int mask_seen = 0;
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hEEEE;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) alu_valid = 1'b0;
            mem_valid = 1'b0;
            if (RegWrite !== 1'b0) writes++;
            if (pending_mask !== 32'd0) mask_seen++;
        end
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL r0_write: writes=%0d want 0", writes);
        end
        checks++;
        if (mask_seen != 0) begin
            errors++;
            $display("FAIL r0_mask: nonzero cycles=%0d want 0", mask_seen);
        end
    endtask

    task automatic test_stream_wrap();
        logic [4:0]  exp_reg  [3] = '{5'd12, 5'd13, 5'd14};
        logic [31:0] exp_data [3] = '{32'hC12, 32'hC13, 32'hC14};
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            mem_valid = (k < 3);
            if (k < 3) begin
                mem_reg  = exp_reg[k];
                mem_data = exp_data[k];
            end
            step();
            if (k >= 1) begin
                checks++;
                if (RegWrite !== 1'b1 || Write_Reg !== exp_reg[k-1] || Write_Bus !== exp_data[k-1]) begin
                    errors++;
                    $display("FAIL stream[%0d]: RegWrite=%b Write_Reg=%0d Write_Bus=%h want 1/%0d/%h",
                             k, RegWrite, Write_Reg, Write_Bus, exp_reg[k-1], exp_data[k-1]);
                end
            end
        end
        idle_inputs();
        step();
        checks++;
        if (RegWrite !== 1'b0 || pending_mask !== 32'd0) begin
            errors++;
            $display("FAIL stream_end: RegWrite=%b mask=%h want 0/0", RegWrite, pending_mask);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_queue();
        test_alu_single();
        test_load_single();
        test_back_to_back();
        test_kill();
        test_same_cycle_kill();
        test_r0();
        test_stream_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
